// File: rtl/canvas_scanout_pkg.sv
// Shared canvas definitions: color encoding and the scanout controller state type.
package canvas_scanout_pkg;

  localparam int COLOR_WIDTH = 8;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scanout_state_t;

endpackage

// File: rtl/canvas_scanout_if.sv
// Canvas memory read port and compositor pixel stream bundles used by canvas_scanout.
interface canvas_rd_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
);
  import canvas_scanout_pkg::*;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                   rd_en;
  logic [XW-1:0]          rd_x;
  logic [YW-1:0]          rd_y;
  logic [COLOR_WIDTH-1:0] rd_color;

  modport master (output rd_en, rd_x, rd_y, input rd_color);
  modport slave  (input rd_en, rd_x, rd_y, output rd_color);
endinterface

interface pix_stream_if #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
);
  import canvas_scanout_pkg::*;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                   pix_valid;
  logic                   pix_ready;
  logic [XW-1:0]          pix_x;
  logic [YW-1:0]          pix_y;
  logic [COLOR_WIDTH-1:0] pix_color;
  logic                   pix_sof;
  logic                   pix_eol;
  logic                   pix_eof;

  modport master (output pix_valid, pix_x, pix_y, pix_color, pix_sof, pix_eol, pix_eof,
                  input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, pix_sof, pix_eol, pix_eof,
                  output pix_ready);
endinterface

// File: rtl/canvas_scanout_pixel_skid_fifo.sv
// Two-entry FIFO holding returned pixels; a push and pop in the same cycle keeps occupancy.
module pixel_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Push into a full FIFO only happens alongside a pop, so the freed head slot is reused.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/canvas_scanout.sv
// Raster-order frame reader: issues 1-cycle-latency reads and streams pixels with SOF/EOL/EOF markers.
module canvas_scanout
  import canvas_scanout_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         frame_done,
  canvas_rd_if.master  rd,
  pix_stream_if.master pix
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int DW = COLOR_WIDTH + XW + YW + 3;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  scanout_state_t r_state, w_state_next;
  logic [XW-1:0] r_x, r_fl_x;
  logic [YW-1:0] r_y, r_fl_y;
  logic          r_inflight, r_fl_sof, r_fl_eol, r_fl_eof, r_frame_done;
  logic          w_rd_en, w_done_next, w_pop, w_full, w_empty, w_last;
  logic [1:0]    w_load;
  logic [DW-1:0] w_push_data, w_head;
  logic [COLOR_WIDTH-1:0] w_head_color;
  logic [XW-1:0] w_head_x;
  logic [YW-1:0] w_head_y;
  logic          w_head_sof, w_head_eol, w_head_eof;

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_pop  = !w_empty && pix.pix_ready;
  // Slots committed after this cycle: buffered + in flight, minus the pixel leaving now.
  assign w_load = {w_full, ~w_full & ~w_empty} + {1'b0, r_inflight} - {1'b0, w_pop};

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = SCAN;
      end
      SCAN: begin
        if (w_load < 2'd2) begin
          w_rd_en = 1'b1;
          if (w_last) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_inflight && (w_empty || (w_pop && !w_full))) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_inflight   <= 1'b0;
      r_fl_x       <= '0;
      r_fl_y       <= '0;
      r_fl_sof     <= 1'b0;
      r_fl_eol     <= 1'b0;
      r_fl_eof     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_done_next;
      r_inflight   <= w_rd_en;
      if (r_state == IDLE && start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_rd_en) begin
        r_fl_x   <= r_x;
        r_fl_y   <= r_y;
        r_fl_sof <= (r_x == '0) && (r_y == '0);
        r_fl_eol <= (r_x == X_LAST);
        r_fl_eof <= w_last;
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign w_push_data = {rd.rd_color, r_fl_x, r_fl_y, r_fl_sof, r_fl_eol, r_fl_eof};

  pixel_skid_fifo #(.DATA_WIDTH(DW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_color, w_head_x, w_head_y, w_head_sof, w_head_eol, w_head_eof} = w_head;

  assign rd.rd_en      = w_rd_en;
  assign rd.rd_x       = r_x;
  assign rd.rd_y       = r_y;
  assign pix.pix_valid = !w_empty;
  assign pix.pix_color = w_empty ? COLOR_NONE : w_head_color;
  assign pix.pix_x     = w_empty ? '0 : w_head_x;
  assign pix.pix_y     = w_empty ? '0 : w_head_y;
  assign pix.pix_sof   = !w_empty && w_head_sof;
  assign pix.pix_eol   = !w_empty && w_head_eol;
  assign pix.pix_eof   = !w_empty && w_head_eof;
  assign busy          = (r_state != IDLE);
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_canvas_scanout.sv
// Scoreboard bench for canvas_scanout on a 4x2 canvas with a synchronous-read memory model.
`timescale 1ns/1ps
module tb_canvas_scanout;
  import canvas_scanout_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done;

  canvas_rd_if  #(.WIDTH(W), .HEIGHT(H)) rd_bus ();
  pix_stream_if #(.WIDTH(W), .HEIGHT(H)) pix_bus ();

  canvas_scanout #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd         (rd_bus),
    .pix        (pix_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_hs = 0;
  int hs_base = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  bit none_mode = 1'b0;
  bit prev_hold = 1'b0;
  logic [31:0] prev_word = '0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pw(input logic [7:0] c, input int x, input int y,
                                     input logic s, input logic e, input logic f);
    return {18'b0, c, 2'(x), 1'(y), s, e, f};
  endfunction

  function automatic logic [COLOR_WIDTH-1:0] mem_color(input int x, input int y);
    if (none_mode && x == 1 && y == 0) return COLOR_NONE;
    return COLOR_WIDTH'(y * W + x);
  endfunction

  // Canvas memory: data valid the cycle after the read request
  always @(posedge clk) begin
    if (rd_bus.rd_en) rd_bus.rd_color <= mem_color(int'(rd_bus.rd_x), int'(rd_bus.rd_y));
  end

  initial begin
    pix_bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (n_hs - hs_base >= 3 && stall_cnt < 5) begin
            pix_bus.pix_ready = 1'b0;
            stall_cnt++;
          end else begin
            pix_bus.pix_ready = 1'b1;
          end
        end
        2: pix_bus.pix_ready = 1'($urandom_range(0, 1));
        3: pix_bus.pix_ready = (n_hs - hs_base < 4);
        default: pix_bus.pix_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] cur;
    cur = pw(pix_bus.pix_color, int'(pix_bus.pix_x), int'(pix_bus.pix_y),
             pix_bus.pix_sof, pix_bus.pix_eol, pix_bus.pix_eof);
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", cur, prev_word);
      if (pix_bus.pix_valid && pix_bus.pix_ready) begin
        n_hs++;
        $display("pixel x=%0d y=%0d color=0x%0h sof=%0b eol=%0b eof=%0b", pix_bus.pix_x,
                 pix_bus.pix_y, pix_bus.pix_color, pix_bus.pix_sof, pix_bus.pix_eol, pix_bus.pix_eof);
        if (sb.size() == 0) check("unexpected_pixel", 32'd1, 32'd0);
        else check("pixel", cur, sb.pop_front());
      end
      if (ready_mode == 1 && !pix_bus.pix_ready) begin
        check("stall_rd_en", rd_bus.rd_en, 1'b0);
        check("stall_valid", pix_bus.pix_valid, 1'b1);
      end
      prev_hold = pix_bus.pix_valid && !pix_bus.pix_ready;
      prev_word = cur;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_rd_en"}, rd_bus.rd_en, 1'b0);
    check({tag, "_rd_xy"}, {rd_bus.rd_x, rd_bus.rd_y}, 3'd0);
    check({tag, "_pix"}, pw(pix_bus.pix_color, int'(pix_bus.pix_x), int'(pix_bus.pix_y),
          pix_bus.pix_sof, pix_bus.pix_eol, pix_bus.pix_eof), pw(COLOR_NONE, 0, 0, 0, 0, 0));
    check({tag, "_valid"}, pix_bus.pix_valid, 1'b0);
  endtask

  task automatic set_mode(input int m);
    stall_cnt = 0;
    ready_mode = m;
  endtask

  task automatic expect_frame();
    hs_base = n_hs;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back(pw(mem_color(x, y), x, y, (x == 0 && y == 0), (x == W - 1),
                        (x == W - 1 && y == H - 1)));
  endtask

  task automatic run_frame(input int exp_cyc, input int restart_k);
    int k;
    int first_v;
    bit done;
    k = 1;
    first_v = 0;
    done = 1'b0;
    expect_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!done && k < 500) begin
      if (k == 1) check("busy_on", busy, 1'b1);
      if (first_v == 0 && pix_bus.pix_valid) first_v = k;
      if (frame_done) begin
        done = 1'b1;
      end else begin
        start = (k == restart_k);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check("frame_done_seen", done, 1'b1);
    if (exp_cyc > 0) begin
      check("frame_cycles", k, exp_cyc);
      check("first_valid_cycle", first_v, 3);
    end
    check("busy_off", busy, 1'b0);
    check("sb_empty", sb.size(), 0);
    check("handshakes", n_hs - hs_base, W * H);
    @(negedge clk);
    check("done_pulse_width", frame_done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    set_mode(0); run_frame(11, 0);
    set_mode(1); run_frame(16, 0);
    set_mode(2); run_frame(0, 0);

    set_mode(0); run_frame(11, 5);
    repeat (3) @(negedge clk);
    check("no_restart_valid", pix_bus.pix_valid, 1'b0);
    check("no_restart_busy", busy, 1'b0);
    run_frame(11, 0);

    set_mode(3);
    expect_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100 && (n_hs - hs_base) < 4; i++) @(negedge clk);
    check("reach_px4", n_hs - hs_base, 4);
    @(negedge clk);
    check("px4_head", pw(pix_bus.pix_color, int'(pix_bus.pix_x), int'(pix_bus.pix_y),
          pix_bus.pix_sof, pix_bus.pix_eol, pix_bus.pix_eof), pw(8'd4, 0, 1, 0, 0, 0));
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b1;
    set_mode(0);
    run_frame(11, 0);

    none_mode = 1'b1;
    run_frame(11, 0);
    none_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
